// File: rtl/audio_dac_tx.sv
`timescale 1ns/1ps
// audio_dac_tx: I2S transmitter for the WM8731 DAC path.
// Left/right sample pairs are buffered in a small FIFO on CLOCK_50. They are
// serialized MSB-first on AUD_DACDAT, using the codec-mastered AUD_BCLK and
// AUD_DACLRCK, which are synchronized into CLOCK_50 before use.
//
// Handshake: a pair is accepted on any CLOCK_50 rising edge where
// write && write_ready. write_ready depends only on the registered fill count,
// so it never combinationally follows write or a same-cycle pop.
module audio_dac_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic                          write,
    input  logic [DATA_WIDTH-1:0]         writedata_left,
    input  logic [DATA_WIDTH-1:0]         writedata_right,
    output logic                          write_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } tx_state_t;

    // Current transmitter state; kept as a named register so checkers can bind to it.
    tx_state_t tx_state;

    logic bclk_s1, bclk_s2, bclk_prev;
    logic lrck_s1, lrck_s2, lr_prev;
    logic fedge, lr_fall, lr_rise;

    logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  fifo_empty, push, pop;

    logic [DATA_WIDTH-1:0] shift_reg, hold_reg;
    logic [BW-1:0]         bit_cnt;

    assign fedge   = bclk_prev & ~bclk_s2;
    assign lr_fall = fedge & lr_prev & ~lrck_s2;
    assign lr_rise = fedge & ~lr_prev & lrck_s2;

    assign fifo_empty  = (count == '0);
    assign write_ready = (count != FULL_COUNT);
    assign push        = write & write_ready;
    assign pop         = lr_fall & ~fifo_empty;
    assign fifo_level  = count;

    // Two-flop synchronizers for the codec clocks, plus the BCLK edge history.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_s1   <= 1'b0;
            bclk_s2   <= 1'b0;
            bclk_prev <= 1'b0;
            lrck_s1   <= 1'b0;
            lrck_s2   <= 1'b0;
        end else begin
            bclk_s1   <= AUD_BCLK;
            bclk_s2   <= bclk_s1;
            bclk_prev <= bclk_s2;
            lrck_s1   <= AUD_DACLRCK;
            lrck_s2   <= lrck_s1;
        end
    end

    // LRCK is sampled only on BCLK falling edges, so frame edges align to bit slots.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            lr_prev <= 1'b0;
        end else if (fedge) begin
            lr_prev <= lrck_s2;
        end
    end

    // Sample storage; contents are don't-care while the count says empty.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_l[wr_ptr] <= writedata_left;
            mem_r[wr_ptr] <= writedata_right;
        end
    end

    // FIFO pointers and fill count; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Transmit FSM; AUD_DACDAT only changes on BCLK falling edges.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            tx_state   <= IDLE;
            shift_reg  <= '0;
            hold_reg   <= '0;
            bit_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (lr_fall) begin
                // Start of a left frame: fetch a pair, or send silence if none is queued.
                underflow  <= fifo_empty;
                shift_reg  <= fifo_empty ? '0 : mem_l[rd_ptr];
                hold_reg   <= fifo_empty ? '0 : mem_r[rd_ptr];
                bit_cnt    <= '0;
                AUD_DACDAT <= 1'b0;
                tx_state   <= LOAD;
            end else if (lr_rise && tx_state != IDLE) begin
                shift_reg  <= hold_reg;
                bit_cnt    <= '0;
                AUD_DACDAT <= 1'b0;
                tx_state   <= LOAD;
            end else if (fedge) begin
                case (tx_state)
                    IDLE: begin
                        AUD_DACDAT <= 1'b0;
                    end
                    LOAD: begin
                        // The delay slot has elapsed; the MSB goes out now.
                        AUD_DACDAT <= shift_reg[DATA_WIDTH-1];
                        shift_reg  <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt    <= BW'(1);
                        tx_state   <= SHIFT;
                    end
                    SHIFT: begin
                        if (bit_cnt == LAST_BIT) begin
                            AUD_DACDAT <= 1'b0;
                            tx_state   <= PAD;
                        end else begin
                            AUD_DACDAT <= shift_reg[DATA_WIDTH-1];
                            shift_reg  <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                            bit_cnt    <= bit_cnt + BW'(1);
                        end
                    end
                    default: begin
                        AUD_DACDAT <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
